// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the SESO 9-bit accumulator core: start/halt handshake,
// LUT-driven branches, load stall. Optional macro CYCLE_COUNT_EN builds the RUN-cycle counter.
module fetch_sequencer #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int MEM_LAT    = 2,
    parameter int LUT_DEPTH  = 16
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic            Branch,
    input  logic            LoadInst,
    input  logic            halt,
    input  logic [3:0]      BrIdx,
    input  logic            LutWrEn,
    input  logic [3:0]      LutAddr,
    input  logic [PC_W-1:0] LutData,
    output logic [PC_W-1:0] ProgCtr,
    output logic            InstrValid,
    output logic            Stall,
    output logic            Done,
    output logic [31:0]     CycleCount
);

    localparam logic [3:0]      LAT      = 4'(MEM_LAT);
    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t          state;
    logic [3:0]      wcnt;
    logic [PC_W-1:0] lut [LUT_DEPTH];
    logic [PC_W-1:0] br_tgt;
    logic            load_wait;
    logic            start_acc;

    // Branch reads the pre-write LUT value when a write hits the same entry.
    assign br_tgt     = lut[BrIdx];
    assign load_wait  = (state == RUN) && !halt && !Branch && LoadInst &&
                        (LAT != 4'd0) && (wcnt < LAT);
    assign start_acc  = Start && (state != RUN);

    assign Stall      = load_wait;
    assign InstrValid = (state == RUN);
    assign Done       = (state == HALTED);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
        end else if (LutWrEn) begin
            lut[LutAddr] <= LutData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            ProgCtr <= '0;
            wcnt    <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    wcnt <= '0;
                    if (Start) begin
                        state   <= RUN;
                        ProgCtr <= START_PC;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state <= HALTED;
                        wcnt  <= '0;
                    end else if (Branch) begin
                        ProgCtr <= br_tgt;
                        wcnt    <= '0;
                    end else if (load_wait) begin
                        wcnt <= wcnt + 4'd1;
                    end else begin
                        // Covers plain sequential flow and the final cycle of a load.
                        ProgCtr <= ProgCtr + 1'b1;
                        wcnt    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            cyc_cnt <= '0;
        else if (start_acc)
            cyc_cnt <= '0;
        else if (state == RUN && cyc_cnt != 32'hFFFF_FFFF)
            cyc_cnt <= cyc_cnt + 32'd1;
    end

    assign CycleCount = cyc_cnt;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign CycleCount       = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a default instance (MEM_LAT=2) and a
// PC_W=4 / START_ADDR=14 / MEM_LAT=0 instance for wrap and no-stall checks.
module tb_fetch_sequencer;

    logic        Clk = 0;
    logic        Reset_n = 0;
    logic        Start = 0, Branch = 0, LoadInst = 0, halt = 0, LutWrEn = 0;
    logic [3:0]  BrIdx = 0, LutAddr = 0;
    logic [9:0]  LutData = 0;
    logic [9:0]  ProgCtr;
    logic        InstrValid, Stall, Done;
    logic [31:0] CycleCount;
    logic [3:0]  pc4;
    logic        iv4, stall4, done4;
    logic [31:0] cc4;

    int total = 0, bad = 0;
    int exp_cyc = 0;
    bit exp_run = 0;

    always #5 Clk = ~Clk;

    fetch_sequencer #(.PC_W(10), .START_ADDR(0), .MEM_LAT(2), .LUT_DEPTH(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Branch(Branch), .LoadInst(LoadInst),
        .halt(halt), .BrIdx(BrIdx), .LutWrEn(LutWrEn), .LutAddr(LutAddr), .LutData(LutData),
        .ProgCtr(ProgCtr), .InstrValid(InstrValid), .Stall(Stall), .Done(Done),
        .CycleCount(CycleCount)
    );

    fetch_sequencer #(.PC_W(4), .START_ADDR(14), .MEM_LAT(0), .LUT_DEPTH(16)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Branch(Branch), .LoadInst(LoadInst),
        .halt(halt), .BrIdx(BrIdx), .LutWrEn(LutWrEn), .LutAddr(LutAddr), .LutData(LutData[3:0]),
        .ProgCtr(pc4), .InstrValid(iv4), .Stall(stall4), .Done(done4), .CycleCount(cc4)
    );

    function automatic logic [31:0] want_cc(input int c);
`ifdef CYCLE_COUNT_EN
        return 32'(c);
`else
        return 32'd0 + 32'(c & 0);
`endif
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
        if (exp_run) exp_cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic test_reset();
        Reset_n = 0;
        #12;
        chk("rst_pc", 32'(ProgCtr), 0);
        chk("rst_valid", 32'(InstrValid), 0);
        chk("rst_stall", 32'(Stall), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_cc", CycleCount, 0);
        Reset_n = 1;
        // Program LUT while idle; Branch/halt inputs must be ignored here.
        LutWrEn = 1; LutAddr = 3; LutData = 10'h040; Branch = 1; BrIdx = 3; halt = 1;
        tick();
        LutAddr = 5; LutData = 10'h004;
        tick();
        LutWrEn = 0; Branch = 0; halt = 0;
        chk("idle_pc", 32'(ProgCtr), 0);
        chk("idle_valid", 32'(InstrValid), 0);
        chk("idle_done", 32'(Done), 0);
    endtask

    task automatic test_sequential();
        Start = 1;
        tick();
        Start = 0;
        exp_cyc = 0; exp_run = 1;
        chk("seq_pc0", 32'(ProgCtr), 0);
        chk("seq_valid", 32'(InstrValid), 1);
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) Start = 1;
            tick();
            Start = 0;
            chk($sformatf("seq_pc%0d", i), 32'(ProgCtr), 32'(i));
            chk("seq_stall", 32'(Stall), 0);
            chk("seq_done", 32'(Done), 0);
        end
        chk("seq_cc", CycleCount, want_cc(exp_cyc));
    endtask

    task automatic test_branch();
        tick(); tick();
        chk("br_pc7", 32'(ProgCtr), 7);
        Branch = 1; BrIdx = 3; LutWrEn = 1; LutAddr = 3; LutData = 10'h080;
        tick();
        LutWrEn = 0;
        chk("br_old_tgt", 32'(ProgCtr), 32'h040);
        tick();
        chk("br_new_tgt", 32'(ProgCtr), 32'h080);
        BrIdx = 5;
        tick();
        Branch = 0;
        chk("br_to_4", 32'(ProgCtr), 4);
    endtask

    task automatic test_load();
        LoadInst = 1;
        #1;
        chk("ld_stall0", 32'(Stall), 1);
        chk("ld_nostall_lat0", 32'(stall4), 0);
        tick();
        chk("ld_pc_hold1", 32'(ProgCtr), 4);
        chk("ld_stall1", 32'(Stall), 1);
        tick();
        chk("ld_pc_hold2", 32'(ProgCtr), 4);
        chk("ld_stall2", 32'(Stall), 0);
        tick();
        LoadInst = 0;
        chk("ld_pc_next", 32'(ProgCtr), 5);
        chk("ld_cc", CycleCount, want_cc(exp_cyc));
    endtask

    task automatic test_halt();
        for (int i = 0; i < 4; i++) tick();
        chk("h_pc9", 32'(ProgCtr), 9);
        halt = 1;
        tick();
        halt = 0;
        exp_run = 0;
        chk("h_done", 32'(Done), 1);
        chk("h_valid", 32'(InstrValid), 0);
        tick(); tick();
        chk("h_pc_hold", 32'(ProgCtr), 9);
        chk("h_done_hold", 32'(Done), 1);
        chk("h_cc_hold", CycleCount, want_cc(exp_cyc));
        Start = 1;
        tick();
        Start = 0;
        exp_cyc = 0; exp_run = 1;
        chk("h_restart_pc", 32'(ProgCtr), 0);
        chk("h_restart_done", 32'(Done), 0);
        chk("h_restart_cc", CycleCount, want_cc(0));
    endtask

    task automatic test_wrap();
        chk("w_pc14", 32'(pc4), 14);
        tick();
        chk("w_pc15", 32'(pc4), 15);
        tick();
        chk("w_pc0", 32'(pc4), 0);
        tick();
        chk("w_pc1", 32'(pc4), 1);
        chk("w_valid", 32'(iv4), 1);
    endtask

    task automatic test_reset_mid_load();
        LoadInst = 1;
        #1;
        chk("rl_stall_pre", 32'(Stall), 1);
        tick();
        #2;
        Reset_n = 0;
        #1;
        chk("rl_pc", 32'(ProgCtr), 0);
        chk("rl_stall", 32'(Stall), 0);
        chk("rl_valid", 32'(InstrValid), 0);
        chk("rl_done", 32'(Done), 0);
        chk("rl_cc", CycleCount, 0);
        LoadInst = 0;
        exp_run = 0;
        #5;
        Reset_n = 1;
        tick(); tick(); tick();
        chk("rl_idle_valid", 32'(InstrValid), 0);
        chk("rl_idle_pc", 32'(ProgCtr), 0);
        // LUT was cleared by reset, so branch via entry 3 lands at 0.
        Start = 1;
        tick();
        Start = 0;
        tick();
        Branch = 1; BrIdx = 3;
        tick();
        Branch = 0;
        chk("rl_lut_cleared", 32'(ProgCtr), 0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_load();
        test_halt();
        test_wrap();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle program-counter sequencer for the SESO 9-bit accumulator core; sits between the instruction ROM and the control decoder.
Takes the decoder's Branch / LoadInst / halt outputs and produces the next program counter.
Branch targets come from a software-configurable 16-entry lookup table.
Stalls the core while a load waits on data memory, and implements the start/halt/done handshake with the test harness.

Parameters:
PC_W, 10, program counter width in bits; PC wraps modulo 2^PC_W.
START_ADDR, 0, PC value loaded on every Start.
MEM_LAT, 2, extra wait cycles per load (0..15); 0 means a single-cycle load.
LUT_DEPTH, 16, branch LUT entries; index width is fixed at 4 bits.

Ports:
Clk  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous active-low reset.
Start  input  1  single-cycle pulse; begins execution from START_ADDR.
Branch  input  1  from decoder; taken branch for the current instruction.
LoadInst  input  1  from decoder; current instruction is ldr.
halt  input  1  from decoder; current instruction is halt.
BrIdx  input  4  branch LUT index (Instruction[3:0]).
LutWrEn  input  1  LUT configuration write strobe.
LutAddr  input  4  LUT write index.
LutData  input  PC_W  LUT write data (absolute target address).
ProgCtr  output  PC_W  address of the current instruction to the instruction ROM.
InstrValid  output  1  high when the current instruction executes this cycle (state RUN).
Stall  output  1  high while a load waits; decoder write enables are qualified with !Stall.
Done  output  1  high in HALTED; the program has finished.
CycleCount  output  32  executed-cycle counter (see Optional Feature).

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=IDLE, ProgCtr=0, Done=0, Stall=0, InstrValid=0, wait counter=0, all LUT entries=0, CycleCount=0.
  - Reset mid-operation aborts any load wait immediately.
- States: IDLE, RUN, HALTED. InstrValid=(state==RUN). Done=(state==HALTED). Both are decoded from registered state.
- IDLE:
  - Start=1 -> RUN next cycle, ProgCtr<=START_ADDR.
  - Branch/LoadInst/halt inputs are ignored.
- RUN, per cycle, with priority halt > Branch > LoadInst > sequential:
  - halt: next state HALTED; ProgCtr holds.
  - Branch: ProgCtr<=LUT[BrIdx] next cycle; no bubble.
  - LoadInst with MEM_LAT>0:
    - Stall=1 combinationally while wcnt<MEM_LAT; wcnt increments and ProgCtr holds.
    - When wcnt==MEM_LAT: Stall=0, ProgCtr<=ProgCtr+1, wcnt<=0.
    - Total load occupancy is MEM_LAT+1 cycles.
  - LoadInst with MEM_LAT=0: behaves as sequential, Stall never asserts.
  - Otherwise: ProgCtr<=ProgCtr+1 (PC_W bits). At 2^PC_W-1 it wraps to 0 with no flag.
  - Start in RUN is ignored.
- HALTED:
  - ProgCtr holds; Done stays high.
  - Start=1 -> RUN, ProgCtr<=START_ADDR; Done drops the cycle after Start.
- Branch LUT:
  - Written synchronously when LutWrEn=1, in any state.
  - Read is combinational. If a write and a branch hit the same entry in the same cycle, the branch uses the old value and the new value is visible next cycle.
- Stall affects only RUN. Branch/halt arriving while Stall=1 cannot happen (the decoder output is held by the stalled PC) and the block does not handle it.

Optional Feature:
Macro CYCLE_COUNT_EN.
- Defined: CycleCount increments by 1 on every cycle with state==RUN, stall cycles included.
  - Clears to 0 on reset and on each accepted Start.
  - Holds in IDLE/HALTED; saturates at 32'hFFFF_FFFF.
- Undefined: the counter is not built and CycleCount is tied to 0.

Test Plan:
- Reset, Start pulse, 5 non-control instructions -> ProgCtr 0,1,2,3,4,5 on consecutive cycles, InstrValid=1, Stall=0, Done=0.
- Write LUT[3]=10'h040, then Branch=1 with BrIdx=3 at PC=7 -> ProgCtr=0x040 next cycle. Same cycle also writes LUT[3]=0x080 -> target still 0x040, and a later branch uses 0x080.
- MEM_LAT=2, LoadInst at PC=4 -> Stall=1 for 2 cycles with ProgCtr=4, then Stall=0 and ProgCtr=5; with CYCLE_COUNT_EN the count includes all 3 cycles.
- halt at PC=9 -> Done=1 next cycle, ProgCtr holds 9, InstrValid=0; a Start pulse -> ProgCtr=START_ADDR, Done=0, and CycleCount clears to 0 when CYCLE_COUNT_EN is defined.
- PC_W=4, sequential run from 14 -> ProgCtr 14,15,0,1.
- Reset_n=0 asserted mid-load (Stall=1) -> all outputs 0 immediately; after release the block waits in IDLE for Start.
